// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IF/ID register and a one-entry skid buffer for stalls.
// Define FETCH_COUNT_EN to add the fetch_count output (count of valid IF/ID loads).
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic [6:0]  opcode
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    typedef enum logic {StFetch, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic        load;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        skid_pc_d     = skid_pc_q;
        skid_instr_d  = skid_instr_q;
        load          = 1'b0;

        if (redirect) begin
            // Squash everything in flight, including a buffered instruction.
            pc_d          = {redirect_pc[31:2], 2'b00};
            if_id_valid_d = 1'b0;
            skid_pc_d     = 32'h0;
            skid_instr_d  = 32'h0;
            state_d       = StFetch;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (stall) begin
                        if (imem_ack) begin
                            skid_pc_d    = pc_q;
                            skid_instr_d = imem_rdata;
                            state_d      = StHold;
                        end
                    end else if (imem_ack) begin
                        if_id_pc_d    = pc_q;
                        if_id_instr_d = imem_rdata;
                        if_id_valid_d = 1'b1;
                        pc_d          = pc_q + 32'd4;
                        load          = 1'b1;
                    end else begin
                        if_id_valid_d = 1'b0;
                    end
                end
                StHold: begin
                    if (!stall) begin
                        if_id_pc_d    = skid_pc_q;
                        if_id_instr_d = skid_instr_q;
                        if_id_valid_d = 1'b1;
                        pc_d          = pc_q + 32'd4;
                        state_d       = StFetch;
                        load          = 1'b1;
                    end
                end
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StFetch;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= 32'h0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            skid_pc_q     <= 32'h0;
            skid_instr_q  <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            skid_pc_q     <= skid_pc_d;
            skid_instr_q  <= skid_instr_d;
        end
    end

    assign imem_req    = (state_q == StFetch);
    assign imem_addr   = pc_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_valid = if_id_valid_q;
    assign if_id_instr = if_id_valid_q ? if_id_instr_q : NOP_INSTR;
    assign opcode      = if_id_instr[6:0];

`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q + {31'b0, load};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= 32'h0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`else
    logic unused_load;
    assign unused_load = load;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the driver queues the expected post-edge outputs,
// a negedge monitor pops and compares them.
module tb_fetch_unit;

    localparam logic [31:0] RstPc = 32'h0000_0100;
    localparam logic [31:0] Nop   = 32'h0000_0013;
    localparam logic [31:0] Junk  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset, stall, redirect, imem_ack;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, if_id_valid;
    logic [31:0] imem_addr, if_id_pc, if_id_instr;
    logic [6:0]  opcode;
`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    fetch_unit #(
        .RESET_PC (RstPc),
        .NOP_INSTR(Nop)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .if_id_pc   (if_id_pc),
        .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid),
        .opcode     (opcode)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count(fetch_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          due;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] ipc;
        logic [31:0] instr;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: outputs after edge N are compared at the following negedge.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            logic ok;
            e  = q.pop_front();
            ok = (e.due == cyc) && (imem_req === e.req) && (imem_addr === e.addr) &&
                 (if_id_valid === e.valid) && (if_id_pc === e.ipc) &&
                 (if_id_instr === e.instr) && (opcode === e.instr[6:0]);
`ifdef FETCH_COUNT_EN
            ok = ok && (fetch_count === e.cnt);
`endif
            n_checks++;
            if (ok) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got req=%b addr=%h valid=%b pc=%h instr=%h op=%b, expected req=%b addr=%h valid=%b pc=%h instr=%h op=%b (cnt exp %0d)",
                         e.name, imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instr,
                         opcode, e.req, e.addr, e.valid, e.ipc, e.instr, e.instr[6:0], e.cnt);
            end
        end
    end

    task automatic drive(input string name, input logic rst, input logic st, input logic rd,
                         input logic [31:0] rpc, input logic ack, input logic [31:0] rdata,
                         input logic req, input logic [31:0] addr, input logic v,
                         input logic [31:0] ipc, input logic [31:0] instr,
                         input logic [31:0] cnt);
        exp_t e;
        reset       = rst;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ack    = ack;
        imem_rdata  = rdata;
        e.name  = name;
        e.due   = cyc + 1;
        e.req   = req;
        e.addr  = addr;
        e.valid = v;
        e.ipc   = ipc;
        e.instr = instr;
        e.cnt   = cnt;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //     name          rst st rd rpc           ack rdata          req addr          v  ipc           instr          cnt
        drive("reset1",      1, 0, 0, 32'h0,       1, Junk,          1, RstPc,        0, 32'h0,        Nop,           0);
        drive("reset2",      1, 0, 0, 32'h0,       1, Junk,          1, 32'h100,      0, 32'h0,        Nop,           0);
        drive("fetch100",    0, 0, 0, 32'h0,       1, 32'h0010_0093, 1, 32'h104,      1, 32'h100,      32'h0010_0093, 1);
        drive("fetch104",    0, 0, 0, 32'h0,       1, 32'h0020_0113, 1, 32'h108,      1, 32'h104,      32'h0020_0113, 2);
        drive("fetch108",    0, 0, 0, 32'h0,       1, 32'h0030_0193, 1, 32'h10C,      1, 32'h108,      32'h0030_0193, 3);
        drive("redir_to4",   0, 0, 1, 32'h4,       1, Junk,          1, 32'h4,        0, 32'h108,      Nop,           3);
        drive("fetch4",      0, 0, 0, 32'h0,       1, 32'h0040_0213, 1, 32'h8,        1, 32'h4,        32'h0040_0213, 4);
        drive("stall_skid",  0, 1, 0, 32'h0,       1, 32'h00A0_0093, 0, 32'h8,        1, 32'h4,        32'h0040_0213, 4);
        drive("hold2",       0, 1, 0, 32'h0,       1, Junk,          0, 32'h8,        1, 32'h4,        32'h0040_0213, 4);
        drive("hold3",       0, 1, 0, 32'h0,       0, Junk,          0, 32'h8,        1, 32'h4,        32'h0040_0213, 4);
        drive("release",     0, 0, 0, 32'h0,       1, Junk,          1, 32'hC,        1, 32'h8,        32'h00A0_0093, 5);
        drive("bubble1",     0, 0, 0, 32'h0,       0, Junk,          1, 32'hC,        0, 32'h8,        Nop,           5);
        drive("bubble2",     0, 0, 0, 32'h0,       0, Junk,          1, 32'hC,        0, 32'h8,        Nop,           5);
        drive("stall_noack", 0, 1, 0, 32'h0,       0, Junk,          1, 32'hC,        0, 32'h8,        Nop,           5);
        drive("fetchC",      0, 0, 0, 32'h0,       1, 32'h0050_0293, 1, 32'h10,       1, 32'hC,        32'h0050_0293, 6);
        drive("stall_hold",  0, 1, 0, 32'h0,       0, Junk,          1, 32'h10,       1, 32'hC,        32'h0050_0293, 6);
        drive("redir_prio",  0, 1, 1, 32'h203,     1, Junk,          1, 32'h200,      0, 32'hC,        Nop,           6);
        drive("skid_200",    0, 1, 0, 32'h0,       1, 32'h0055_0013, 0, 32'h200,      0, 32'hC,        Nop,           6);
        drive("redir_hold",  0, 1, 1, 32'hFFFF_FFFC, 1, Junk,        1, 32'hFFFF_FFFC, 0, 32'hC,       Nop,           6);
        drive("wrap",        0, 0, 0, 32'h0,       1, 32'h0060_0313, 1, 32'h0,        1, 32'hFFFF_FFFC, 32'h0060_0313, 7);
        drive("fetch0",      0, 0, 0, 32'h0,       1, 32'h0070_0393, 1, 32'h4,        1, 32'h0,        32'h0070_0393, 8);
        drive("skid_4",      0, 1, 0, 32'h0,       1, 32'h0080_0413, 0, 32'h4,        1, 32'h0,        32'h0070_0393, 8);
        drive("reset_hold",  1, 1, 0, 32'h0,       1, Junk,          1, 32'h100,      0, 32'h0,        Nop,           0);
        drive("no_ghost",    0, 0, 0, 32'h0,       0, Junk,          1, 32'h100,      0, 32'h0,        Nop,           0);
        drive("refetch100",  0, 0, 0, 32'h0,       1, 32'h0090_0493, 1, 32'h104,      1, 32'h100,      32'h0090_0493, 1);
        drive("reset_prio",  1, 1, 1, 32'h40,      1, Junk,          1, 32'h100,      0, 32'h0,        Nop,           0);
        drive("after_rst",   0, 0, 0, 32'h0,       0, Junk,          1, 32'h100,      0, 32'h0,        Nop,           0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded by reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), instruction presented when IF/ID is empty.
REQ-003 SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  hazard hold; IF/ID must not change.
REQ-006 SHALL have port redirect  input  1  taken branch; squash and refetch.
REQ-007 SHALL have port redirect_pc  input  32  branch target.
REQ-008 SHALL have port imem_req  output  1  fetch request.
REQ-009 SHALL have port imem_addr  output  32  word-aligned fetch address.
REQ-010 SHALL have port imem_rdata  input  32  instruction for imem_addr, valid when imem_ack=1.
REQ-011 SHALL have port imem_ack  input  1  same-cycle completion; memory holds no outstanding state.
REQ-012 SHALL have ports if_id_pc (output, 32, PC of held instruction), if_id_instr (output, 32, held instruction), if_id_valid (output, 1, IF/ID holds a real instruction).
REQ-013 SHALL have port opcode  output  7  if_id_instr[6:0], feeds the main decoder.

Function
REQ-014 SHALL implement FSM states FETCH and HOLD, all state/registers updating only on rising clk.
REQ-015 SHALL, in FETCH, drive imem_req=1 and imem_addr=pc; in HOLD, drive imem_req=0, imem_addr=pc.
REQ-016 SHALL, in FETCH with imem_ack=1, stall=0, redirect=0: load IF/ID with {pc, imem_rdata}, valid=1, pc<=pc+4, stay FETCH (one instruction per cycle when memory acks every cycle).
REQ-017 SHALL, in FETCH with imem_ack=1, stall=1, redirect=0: capture {pc, imem_rdata} into a one-entry skid buffer, keep IF/ID unchanged, go HOLD.
REQ-018 SHALL, in HOLD with stall=0, redirect=0: move skid buffer into IF/ID with valid=1, pc<=pc+4, go FETCH.
REQ-019 SHALL, in FETCH with imem_ack=0, stall=0: set if_id_valid<=0 (bubble); with stall=1 hold IF/ID unchanged.
REQ-020 SHALL, whenever redirect=1 and reset=0 (any state, overriding stall and imem_ack): pc<={redirect_pc[31:2],2'b00}, if_id_valid<=0, skid buffer discarded, state<=FETCH.
REQ-021 SHALL drive if_id_instr=NOP_INSTR whenever if_id_valid=0, so opcode=7'b0010011 for bubbles.
REQ-022 SHALL compute pc+4 modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-023 SHALL apply priority reset > redirect > stall > imem_ack.

Reset
REQ-024 SHALL, on clk edge with reset=1: pc<=RESET_PC, state<=FETCH, if_id_valid<=0, if_id_pc<=0, skid buffer cleared, regardless of stall/redirect/imem_ack.
REQ-025 SHALL drive imem_req=1 and imem_addr=RESET_PC in the first cycle after reset deasserts.
REQ-026 SHALL, on reset asserted mid-HOLD, discard the buffered instruction and never deliver it.

Configuration
REQ-027 SHALL, with macro FETCH_COUNT_EN defined, provide output fetch_count (32 bits), reset to 0, incremented by 1 (wrapping) each cycle IF/ID is loaded with valid=1 (REQ-016, REQ-018).
REQ-028 SHALL, without FETCH_COUNT_EN, omit the fetch_count port and its counter, all other behaviour identical.

Verification
REQ-029 SHALL verify reset: RESET_PC=32'h100, reset 2 cycles, ack every cycle -> imem_addr 0x100,0x104,0x108; if_id_pc follows one cycle later; if_id_valid=0 first cycle.
REQ-030 SHALL verify stall skid: ack with rdata=32'h00A00093 at pc=0x8 while stall=1 for 3 cycles -> state HOLD, imem_req=0, IF/ID unchanged; stall drops -> if_id_instr=32'h00A00093, if_id_pc=0x8, next imem_addr=0xC.
REQ-031 SHALL verify redirect priority: redirect=1, redirect_pc=32'h203, stall=1, imem_ack=1 same cycle -> next imem_addr=0x200, if_id_valid=0, opcode=7'b0010011.
REQ-032 SHALL verify bubbles: imem_ack=0 for 2 cycles, stall=0 -> if_id_valid=0, if_id_instr=32'h00000013; pc held.
REQ-033 SHALL verify wrap: pc=32'hFFFF_FFFC acked -> next imem_addr=32'h0.
REQ-034 SHALL verify, with FETCH_COUNT_EN, 5 acked fetches, one stalled-and-released, one redirect-squashed -> fetch_count=5 plus released instruction = 6; reset returns it to 0.
